// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode and ALU control constants, the strobe bundle and decode helpers.
package control_pkg;

   localparam int OPW   = 5;
   localparam int CTRLW = 4;

   // One state per clock: fetch T0-T2, execute T3-T7, plus reset and halt.
   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } state_t;

   // Opcodes (IR[31:27]).
   localparam logic [OPW-1:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
   localparam logic [OPW-1:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
   localparam logic [OPW-1:0] OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHRA = 5'd8;
   localparam logic [OPW-1:0] OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
   localparam logic [OPW-1:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
   localparam logic [OPW-1:0] OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17;
   localparam logic [OPW-1:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20;
   localparam logic [OPW-1:0] OP_IN   = 5'd22, OP_OUT  = 5'd23, OP_MFHI = 5'd24;
   localparam logic [OPW-1:0] OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

   // ALU operation codes driven on ctrl.
   localparam logic [CTRLW-1:0] ALU_AND  = 4'd0,  ALU_OR   = 4'd1,  ALU_ADD = 4'd2;
   localparam logic [CTRLW-1:0] ALU_SUB  = 4'd3,  ALU_SHR  = 4'd4,  ALU_SHRA = 4'd5;
   localparam logic [CTRLW-1:0] ALU_SHL  = 4'd6,  ALU_ROR  = 4'd7,  ALU_ROL = 4'd8;
   localparam logic [CTRLW-1:0] ALU_MUL  = 4'd9,  ALU_DIV  = 4'd10, ALU_NEG = 4'd11;
   localparam logic [CTRLW-1:0] ALU_NOT  = 4'd12;

   // Instruction families that share one execute micro-sequence.
   typedef enum logic [3:0] {
      CL_REG, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
   } op_class_t;

   // Every control strobe the sequencer produces, as one bundle.
   typedef struct packed {
      logic             PCout;
      logic             Zlowout;
      logic             Zhighout;
      logic             MDRout;
      logic             HIout;
      logic             LOout;
      logic             InPortout;
      logic             Cout;
      logic             BAout;
      logic             Rout;
      logic             MARin;
      logic             MDRin;
      logic             IRin;
      logic             Yin;
      logic             PCin;
      logic             Zlowin;
      logic             Zhighin;
      logic             HIin;
      logic             LOin;
      logic             Rin;
      logic             CONin;
      logic             outPortEnable;
      logic             Gra;
      logic             Grb;
      logic             Grc;
      logic             IncPC;
      logic             Read;
      logic             wren;
      logic [CTRLW-1:0] ctrl;
   } strobes_t;

   // Map an opcode to its execute family; unknown opcodes behave as nop.
   function automatic op_class_t op_class(input logic [OPW-1:0] op);
      op_class_t c;
      case (op)
         OP_LD:                                c = CL_LD;
         OP_LDI:                               c = CL_LDI;
         OP_ST:                                c = CL_ST;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      c = CL_REG;
         OP_ADDI, OP_ANDI, OP_ORI:             c = CL_IMM;
         OP_MUL, OP_DIV:                       c = CL_MULDIV;
         OP_NEG, OP_NOT:                       c = CL_UNARY;
         OP_BR:                                c = CL_BR;
         OP_JR:                                c = CL_JR;
         OP_IN:                                c = CL_IN;
         OP_OUT:                               c = CL_OUT;
         OP_MFHI:                              c = CL_MFHI;
         OP_MFLO:                              c = CL_MFLO;
         OP_HALT:                              c = CL_HALT;
         OP_NOP:                               c = CL_NOP;
         default:                              c = CL_NOP;
      endcase
      return c;
   endfunction

   // Final execute step of each family; nop and halt end with fetch.
   function automatic state_t last_step(input op_class_t c);
      state_t s;
      case (c)
         CL_LD, CL_ST:                         s = ST_T7;
         CL_MULDIV, CL_BR:                     s = ST_T6;
         CL_REG, CL_IMM, CL_LDI:               s = ST_T5;
         CL_UNARY:                             s = ST_T4;
         CL_JR, CL_IN, CL_OUT, CL_MFHI,
         CL_MFLO:                              s = ST_T3;
         default:                              s = ST_T2;
      endcase
      return s;
   endfunction

   // ALU code an opcode requests when its sequence drives ctrl.
   function automatic logic [CTRLW-1:0] alu_code(input logic [OPW-1:0] op);
      logic [CTRLW-1:0] a;
      case (op)
         OP_ADD, OP_ADDI: a = ALU_ADD;
         OP_SUB:          a = ALU_SUB;
         OP_AND, OP_ANDI: a = ALU_AND;
         OP_OR, OP_ORI:   a = ALU_OR;
         OP_SHR:          a = ALU_SHR;
         OP_SHRA:         a = ALU_SHRA;
         OP_SHL:          a = ALU_SHL;
         OP_ROR:          a = ALU_ROR;
         OP_ROL:          a = ALU_ROL;
         OP_MUL:          a = ALU_MUL;
         OP_DIV:          a = ALU_DIV;
         OP_NEG:          a = ALU_NEG;
         OP_NOT:          a = ALU_NOT;
         default:         a = ALU_AND;
      endcase
      return a;
   endfunction

   // Plain sequential successor of a step (sequence ends are handled by the caller).
   function automatic state_t next_step(input state_t s);
      state_t n;
      case (s)
         ST_T0:   n = ST_T1;
         ST_T1:   n = ST_T2;
         ST_T2:   n = ST_T3;
         ST_T3:   n = ST_T4;
         ST_T4:   n = ST_T5;
         ST_T5:   n = ST_T6;
         ST_T6:   n = ST_T7;
         default: n = ST_T0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/step_decoder.sv
// Combinational microcode: turns (step, opcode, branch condition) into the
// full strobe bundle. Anything not named for a step stays 0.
module step_decoder
   import control_pkg::*;
(
   input  state_t         i_state,
   input  logic [OPW-1:0] i_opcode,
   input  logic           i_con_ff,
   output strobes_t       o_strobes
);

   op_class_t        w_class;
   logic [CTRLW-1:0] w_alu;

   assign w_class = op_class(i_opcode);
   assign w_alu   = alu_code(i_opcode);

   // Strobe decode per step; fetch is opcode-independent, execute is per family.
   always_comb begin
      o_strobes = '0;
      case (i_state)
         ST_T0: begin
            o_strobes.PCout  = 1'b1;
            o_strobes.MARin  = 1'b1;
            o_strobes.IncPC  = 1'b1;
            o_strobes.Zlowin = 1'b1;
         end
         ST_T1: begin
            o_strobes.Zlowout = 1'b1;
            o_strobes.PCin    = 1'b1;
            o_strobes.Read    = 1'b1;
            o_strobes.MDRin   = 1'b1;
         end
         ST_T2: begin
            o_strobes.MDRout = 1'b1;
            o_strobes.IRin   = 1'b1;
         end
         ST_T3: begin
            case (w_class)
               CL_REG, CL_IMM: begin
                  o_strobes.Grb  = 1'b1;
                  o_strobes.Rout = 1'b1;
                  o_strobes.Yin  = 1'b1;
               end
               CL_MULDIV: begin
                  o_strobes.Gra  = 1'b1;
                  o_strobes.Rout = 1'b1;
                  o_strobes.Yin  = 1'b1;
               end
               CL_UNARY: begin
                  o_strobes.Grb    = 1'b1;
                  o_strobes.Rout   = 1'b1;
                  o_strobes.ctrl   = w_alu;
                  o_strobes.Zlowin = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  o_strobes.Grb   = 1'b1;
                  o_strobes.BAout = 1'b1;
                  o_strobes.Yin   = 1'b1;
               end
               CL_BR: begin
                  o_strobes.Gra   = 1'b1;
                  o_strobes.Rout  = 1'b1;
                  o_strobes.CONin = 1'b1;
               end
               CL_JR: begin
                  o_strobes.Gra  = 1'b1;
                  o_strobes.Rout = 1'b1;
                  o_strobes.PCin = 1'b1;
               end
               CL_IN: begin
                  o_strobes.InPortout = 1'b1;
                  o_strobes.Gra       = 1'b1;
                  o_strobes.Rin       = 1'b1;
               end
               CL_OUT: begin
                  o_strobes.Gra           = 1'b1;
                  o_strobes.Rout          = 1'b1;
                  o_strobes.outPortEnable = 1'b1;
               end
               CL_MFHI: begin
                  o_strobes.HIout = 1'b1;
                  o_strobes.Gra   = 1'b1;
                  o_strobes.Rin   = 1'b1;
               end
               CL_MFLO: begin
                  o_strobes.LOout = 1'b1;
                  o_strobes.Gra   = 1'b1;
                  o_strobes.Rin   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (w_class)
               CL_REG: begin
                  o_strobes.Grc    = 1'b1;
                  o_strobes.Rout   = 1'b1;
                  o_strobes.ctrl   = w_alu;
                  o_strobes.Zlowin = 1'b1;
               end
               CL_IMM: begin
                  o_strobes.Cout   = 1'b1;
                  o_strobes.ctrl   = w_alu;
                  o_strobes.Zlowin = 1'b1;
               end
               CL_MULDIV: begin
                  o_strobes.Grb     = 1'b1;
                  o_strobes.Rout    = 1'b1;
                  o_strobes.ctrl    = w_alu;
                  o_strobes.Zlowin  = 1'b1;
                  o_strobes.Zhighin = 1'b1;
               end
               CL_UNARY: begin
                  o_strobes.Zlowout = 1'b1;
                  o_strobes.Gra     = 1'b1;
                  o_strobes.Rin     = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  o_strobes.Cout   = 1'b1;
                  o_strobes.ctrl   = ALU_ADD;
                  o_strobes.Zlowin = 1'b1;
               end
               CL_BR: begin
                  o_strobes.PCout = 1'b1;
                  o_strobes.Yin   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (w_class)
               CL_REG, CL_IMM, CL_LDI: begin
                  o_strobes.Zlowout = 1'b1;
                  o_strobes.Gra     = 1'b1;
                  o_strobes.Rin     = 1'b1;
               end
               CL_MULDIV: begin
                  o_strobes.Zlowout = 1'b1;
                  o_strobes.LOin    = 1'b1;
               end
               CL_LD, CL_ST: begin
                  o_strobes.Zlowout = 1'b1;
                  o_strobes.MARin   = 1'b1;
               end
               CL_BR: begin
                  o_strobes.Cout   = 1'b1;
                  o_strobes.ctrl   = ALU_ADD;
                  o_strobes.Zlowin = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (w_class)
               CL_MULDIV: begin
                  o_strobes.Zhighout = 1'b1;
                  o_strobes.HIin     = 1'b1;
               end
               CL_LD: begin
                  o_strobes.Read  = 1'b1;
                  o_strobes.MDRin = 1'b1;
               end
               CL_ST: begin
                  o_strobes.Gra   = 1'b1;
                  o_strobes.Rout  = 1'b1;
                  o_strobes.MDRin = 1'b1;
               end
               CL_BR: begin
                  // Branch target is written back only when the condition held.
                  o_strobes.Zlowout = i_con_ff;
                  o_strobes.PCin    = i_con_ff;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (w_class)
               CL_LD: begin
                  o_strobes.MDRout = 1'b1;
                  o_strobes.Gra    = 1'b1;
                  o_strobes.Rin    = 1'b1;
               end
               CL_ST: begin
                  o_strobes.wren = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: one state per clock, fetch T0-T2 then an
// opcode-dependent execute sequence, with halt at instruction boundaries.
// Clear low forces RST asynchronously, which decodes to all strobes 0.
// r_state (type state_t) is the single FSM state register.
module control_sequencer
   import control_pkg::*;
(
   input  logic             Clock,
   input  logic             Clear,
   input  logic [31:0]      IR,
   input  logic             CON_FF,
   input  logic             Stop,
   output logic             PCout,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             MDRout,
   output logic             HIout,
   output logic             LOout,
   output logic             InPortout,
   output logic             Cout,
   output logic             BAout,
   output logic             Rout,
   output logic             MARin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             PCin,
   output logic             Zlowin,
   output logic             Zhighin,
   output logic             HIin,
   output logic             LOin,
   output logic             Rin,
   output logic             CONin,
   output logic             outPortEnable,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             IncPC,
   output logic             Read,
   output logic             wren,
   output logic [CTRLW-1:0] ctrl,
   output logic             Run
);

   state_t         r_state;
   state_t         w_next;
   state_t         w_last;
   op_class_t      w_class;
   logic [OPW-1:0] w_opcode;
   strobes_t       w_strobes;
   logic           w_unused_ir;

   // Only the opcode field steers sequencing; operand fields go to the datapath.
   assign w_opcode    = IR[31 -: OPW];
   assign w_unused_ir = ^IR[31-OPW:0];
   assign w_class     = op_class(w_opcode);
   assign w_last      = last_step(w_class);

   // State register with asynchronous clear.
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r_state <= ST_RST;
      end else begin
         r_state <= w_next;
      end
   end

   // Next step: advance, end the sequence into T0, or park in HALT.
   // nop/halt are resolved at T2 from the IR word presented in that cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RST:  w_next = ST_T0;
         ST_T0:   w_next = ST_T1;
         ST_T1:   w_next = ST_T2;
         ST_HALT: w_next = ST_HALT;
         default: begin
            if ((r_state == ST_T2) && (w_class == CL_HALT)) begin
               w_next = ST_HALT;
            end else if (r_state == w_last) begin
               w_next = Stop ? ST_HALT : ST_T0;
            end else begin
               w_next = next_step(r_state);
            end
         end
      endcase
   end

   step_decoder u_step_decoder (
      .i_state   (r_state),
      .i_opcode  (w_opcode),
      .i_con_ff  (CON_FF),
      .o_strobes (w_strobes)
   );

   assign PCout         = w_strobes.PCout;
   assign Zlowout       = w_strobes.Zlowout;
   assign Zhighout      = w_strobes.Zhighout;
   assign MDRout        = w_strobes.MDRout;
   assign HIout         = w_strobes.HIout;
   assign LOout         = w_strobes.LOout;
   assign InPortout     = w_strobes.InPortout;
   assign Cout          = w_strobes.Cout;
   assign BAout         = w_strobes.BAout;
   assign Rout          = w_strobes.Rout;
   assign MARin         = w_strobes.MARin;
   assign MDRin         = w_strobes.MDRin;
   assign IRin          = w_strobes.IRin;
   assign Yin           = w_strobes.Yin;
   assign PCin          = w_strobes.PCin;
   assign Zlowin        = w_strobes.Zlowin;
   assign Zhighin       = w_strobes.Zhighin;
   assign HIin          = w_strobes.HIin;
   assign LOin          = w_strobes.LOin;
   assign Rin           = w_strobes.Rin;
   assign CONin         = w_strobes.CONin;
   assign outPortEnable = w_strobes.outPortEnable;
   assign Gra           = w_strobes.Gra;
   assign Grb           = w_strobes.Grb;
   assign Grc           = w_strobes.Grc;
   assign IncPC         = w_strobes.IncPC;
   assign Read          = w_strobes.Read;
   assign wren          = w_strobes.wren;
   assign ctrl          = w_strobes.ctrl;

   // Running everywhere except HALT; held low while Clear is asserted.
   assign Run = Clear && (r_state != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written corner
// sequences, then randomized instruction streams against a micro-program model.
module tb_control_sequencer;

   logic        Clock, Clear, CON_FF, Stop;
   logic [31:0] IR;
   logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
   logic MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, Rin, CONin, outPortEnable;
   logic Gra, Grb, Grc, IncPC, Read, wren, Run;
   logic [3:0] ctrl;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
      .BAout(BAout), .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .PCin(PCin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin),
      .LOin(LOin), .Rin(Rin), .CONin(CONin), .outPortEnable(outPortEnable),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .wren(wren),
      .ctrl(ctrl), .Run(Run)
   );

   // Observed outputs packed as {Run, ctrl, 28 strobes}.
   logic [32:0] w_dut;
   assign w_dut = {Run, ctrl, wren, Read, IncPC, Grc, Grb, Gra, outPortEnable, CONin,
                   Rin, LOin, HIin, Zhighin, Zlowin, PCin, Yin, IRin, MDRin, MARin,
                   Rout, BAout, Cout, InPortout, LOout, HIout, MDRout, Zhighout,
                   Zlowout, PCout};

   localparam logic [32:0] B_PCOUT  = 33'd1 << 0,  B_ZLOWOUT = 33'd1 << 1;
   localparam logic [32:0] B_ZHIOUT = 33'd1 << 2,  B_MDROUT  = 33'd1 << 3;
   localparam logic [32:0] B_HIOUT  = 33'd1 << 4,  B_LOOUT   = 33'd1 << 5;
   localparam logic [32:0] B_INPORT = 33'd1 << 6,  B_COUT    = 33'd1 << 7;
   localparam logic [32:0] B_BAOUT  = 33'd1 << 8,  B_ROUT    = 33'd1 << 9;
   localparam logic [32:0] B_MARIN  = 33'd1 << 10, B_MDRIN   = 33'd1 << 11;
   localparam logic [32:0] B_IRIN   = 33'd1 << 12, B_YIN     = 33'd1 << 13;
   localparam logic [32:0] B_PCIN   = 33'd1 << 14, B_ZLOWIN  = 33'd1 << 15;
   localparam logic [32:0] B_ZHIIN  = 33'd1 << 16, B_HIIN    = 33'd1 << 17;
   localparam logic [32:0] B_LOIN   = 33'd1 << 18, B_RIN     = 33'd1 << 19;
   localparam logic [32:0] B_CONIN  = 33'd1 << 20, B_OUTPE   = 33'd1 << 21;
   localparam logic [32:0] B_GRA    = 33'd1 << 22, B_GRB     = 33'd1 << 23;
   localparam logic [32:0] B_GRC    = 33'd1 << 24, B_INCPC   = 33'd1 << 25;
   localparam logic [32:0] B_READ   = 33'd1 << 26, B_WREN    = 33'd1 << 27;
   localparam logic [32:0] B_RUN    = 33'd1 << 32;

   localparam logic [32:0] F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
   localparam logic [32:0] F1 = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
   localparam logic [32:0] F2 = B_RUN | B_MDROUT | B_IRIN;

   int n_pass  = 0;
   int n_total = 0;

   function automatic logic [32:0] ct(input int c);
      ct = {1'b0, 4'(c), 28'd0};
   endfunction

   function automatic logic [31:0] mk_ir(input int op);
      mk_ir = {5'(op), 27'h2A5C3B1};
   endfunction

   task automatic check(input string name, input logic [32:0] exp);
      n_total++;
      if (w_dut === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, w_dut, exp, $time);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // clock / reset
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   // Assert Clear (outputs must drop at once), then release at a falling edge.
   task automatic do_reset();
      Clear = 1'b0;
      Stop  = 1'b0;
      #1;
      check("reset_zero", 33'd0);
      @(negedge Clock);
      Clear = 1'b1;
      #1;
      check("rst_state_run", B_RUN);
   endtask

   task automatic tick();
      @(negedge Clock);
      #1;
   endtask

   // Reset, hold IR/CON_FF, and advance to step Tk (k = 0..7).
   task automatic run_to(input logic [31:0] ir, input logic con, input int k);
      @(negedge Clock);
      IR     = ir;
      CON_FF = con;
      do_reset();
      repeat (k + 1) tick();
   endtask

   // Directed vectors: {IR, CON_FF, step, expected outputs}.
   typedef struct {
      logic [31:0] ir;
      logic        con;
      int          step;
      logic [32:0] exp;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];

   // Micro-program model: execute-step words per opcode (fetch is common).
   logic [32:0] exec_tab [32][5];
   int          exec_len [32];

   task automatic build_model();
      for (int op = 0; op < 32; op++) begin
         exec_len[op] = 0;
         for (int s = 0; s < 5; s++) exec_tab[op][s] = '0;
      end
      begin
         int code [32];
         for (int op = 0; op < 32; op++) code[op] = 0;
         code[3] = 2; code[4] = 3; code[5] = 0; code[6] = 1; code[7] = 4;
         code[8] = 5; code[9] = 6; code[10] = 7; code[11] = 8;
         code[12] = 2; code[13] = 0; code[14] = 1;
         code[15] = 9; code[16] = 10; code[17] = 11; code[18] = 12;
         for (int op = 3; op <= 11; op++) begin
            exec_len[op] = 3;
            exec_tab[op][0] = B_GRB | B_ROUT | B_YIN;
            exec_tab[op][1] = B_GRC | B_ROUT | B_ZLOWIN | ct(code[op]);
            exec_tab[op][2] = B_ZLOWOUT | B_GRA | B_RIN;
         end
         for (int op = 12; op <= 14; op++) begin
            exec_len[op] = 3;
            exec_tab[op][0] = B_GRB | B_ROUT | B_YIN;
            exec_tab[op][1] = B_COUT | B_ZLOWIN | ct(code[op]);
            exec_tab[op][2] = B_ZLOWOUT | B_GRA | B_RIN;
         end
         for (int op = 15; op <= 16; op++) begin
            exec_len[op] = 4;
            exec_tab[op][0] = B_GRA | B_ROUT | B_YIN;
            exec_tab[op][1] = B_GRB | B_ROUT | B_ZLOWIN | B_ZHIIN | ct(code[op]);
            exec_tab[op][2] = B_ZLOWOUT | B_LOIN;
            exec_tab[op][3] = B_ZHIOUT | B_HIIN;
         end
         for (int op = 17; op <= 18; op++) begin
            exec_len[op] = 2;
            exec_tab[op][0] = B_GRB | B_ROUT | B_ZLOWIN | ct(code[op]);
            exec_tab[op][1] = B_ZLOWOUT | B_GRA | B_RIN;
         end
      end
      for (int op = 0; op <= 2; op++) begin
         exec_tab[op][0] = B_GRB | B_BAOUT | B_YIN;
         exec_tab[op][1] = B_COUT | B_ZLOWIN | ct(2);
      end
      exec_len[0] = 5;
      exec_tab[0][2] = B_ZLOWOUT | B_MARIN;
      exec_tab[0][3] = B_READ | B_MDRIN;
      exec_tab[0][4] = B_MDROUT | B_GRA | B_RIN;
      exec_len[1] = 3;
      exec_tab[1][2] = B_ZLOWOUT | B_GRA | B_RIN;
      exec_len[2] = 5;
      exec_tab[2][2] = B_ZLOWOUT | B_MARIN;
      exec_tab[2][3] = B_GRA | B_ROUT | B_MDRIN;
      exec_tab[2][4] = B_WREN;
      exec_len[19] = 4;
      exec_tab[19][0] = B_GRA | B_ROUT | B_CONIN;
      exec_tab[19][1] = B_PCOUT | B_YIN;
      exec_tab[19][2] = B_COUT | B_ZLOWIN | ct(2);
      exec_tab[19][3] = '0;
      exec_len[20] = 1; exec_tab[20][0] = B_GRA | B_ROUT | B_PCIN;
      exec_len[22] = 1; exec_tab[22][0] = B_INPORT | B_GRA | B_RIN;
      exec_len[23] = 1; exec_tab[23][0] = B_GRA | B_ROUT | B_OUTPE;
      exec_len[24] = 1; exec_tab[24][0] = B_HIOUT | B_GRA | B_RIN;
      exec_len[25] = 1; exec_tab[25][0] = B_LOOUT | B_GRA | B_RIN;
   endtask

   // Random instruction stream; the model predicts every cycle's outputs.
   task automatic rand_phase(input int ncycles);
      logic [32:0] q [$];
      logic [32:0] exp;
      logic [4:0]  op;
      bit          halted;
      bit          halt_after;
      halted     = 1'b0;
      halt_after = 1'b0;
      @(negedge Clock);
      do_reset();
      for (int c = 0; c < ncycles; c++) begin
         @(negedge Clock);
         if (halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0)) begin
            do_reset();
            q.delete();
            halted = 1'b0;
            continue;
         end
         if (!halted && q.size() == 0) begin
            op     = 5'($urandom_range(0, 31));
            IR     = {op, 27'($urandom)};
            CON_FF = 1'($urandom_range(0, 1));
            halt_after = (op == 5'd27);
            q.push_back(F0);
            q.push_back(F1);
            q.push_back(F2);
            for (int s = 0; s < exec_len[op]; s++) begin
               exp = exec_tab[op][s] | B_RUN;
               if (op == 5'd19 && s == 3 && CON_FF) exp = exp | B_ZLOWOUT | B_PCIN;
               q.push_back(exp);
            end
         end
         #1;
         exp = halted ? 33'd0 : q.pop_front();
         check("random_step", exp);
         Stop = ($urandom_range(0, 15) == 0);
         if (!halted && q.size() == 0 && (halt_after || Stop)) halted = 1'b1;
      end
   endtask

   initial begin
      int n;
      Clear  = 1'b0;
      IR     = '0;
      CON_FF = 1'b0;
      Stop   = 1'b0;
      build_model();

      vecs[0]  = '{32'h68900005, 1'b0, 3, B_RUN | B_GRB | B_ROUT | B_YIN};
      vecs[1]  = '{32'h68900005, 1'b0, 4, B_RUN | B_COUT | B_ZLOWIN | ct(0)};
      vecs[2]  = '{32'h68900005, 1'b0, 5, B_RUN | B_ZLOWOUT | B_GRA | B_RIN};
      vecs[3]  = '{mk_ir(0),  1'b0, 3, B_RUN | B_GRB | B_BAOUT | B_YIN};
      vecs[4]  = '{mk_ir(0),  1'b0, 4, B_RUN | B_COUT | B_ZLOWIN | ct(2)};
      vecs[5]  = '{mk_ir(0),  1'b0, 5, B_RUN | B_ZLOWOUT | B_MARIN};
      vecs[6]  = '{mk_ir(0),  1'b0, 6, B_RUN | B_READ | B_MDRIN};
      vecs[7]  = '{mk_ir(0),  1'b0, 7, B_RUN | B_MDROUT | B_GRA | B_RIN};
      vecs[8]  = '{mk_ir(2),  1'b0, 6, B_RUN | B_GRA | B_ROUT | B_MDRIN};
      vecs[9]  = '{mk_ir(2),  1'b0, 7, B_RUN | B_WREN};
      vecs[10] = '{mk_ir(19), 1'b0, 6, B_RUN};
      vecs[11] = '{mk_ir(19), 1'b1, 6, B_RUN | B_ZLOWOUT | B_PCIN};
      vecs[12] = '{mk_ir(19), 1'b1, 3, B_RUN | B_GRA | B_ROUT | B_CONIN};
      vecs[13] = '{mk_ir(15), 1'b0, 4, B_RUN | B_GRB | B_ROUT | B_ZLOWIN | B_ZHIIN | ct(9)};
      vecs[14] = '{mk_ir(15), 1'b0, 5, B_RUN | B_ZLOWOUT | B_LOIN};
      vecs[15] = '{mk_ir(15), 1'b0, 6, B_RUN | B_ZHIOUT | B_HIIN};
      vecs[16] = '{mk_ir(4),  1'b0, 4, B_RUN | B_GRC | B_ROUT | B_ZLOWIN | ct(3)};
      vecs[17] = '{mk_ir(17), 1'b0, 3, B_RUN | B_GRB | B_ROUT | B_ZLOWIN | ct(11)};
      vecs[18] = '{mk_ir(20), 1'b0, 3, B_RUN | B_GRA | B_ROUT | B_PCIN};
      vecs[19] = '{mk_ir(23), 1'b0, 3, B_RUN | B_GRA | B_ROUT | B_OUTPE};
      vecs[20] = '{mk_ir(1),  1'b0, 5, B_RUN | B_ZLOWOUT | B_GRA | B_RIN};
      vecs[21] = '{mk_ir(16), 1'b0, 3, B_RUN | B_GRA | B_ROUT | B_YIN};
      vecs[22] = '{mk_ir(24), 1'b0, 3, B_RUN | B_HIOUT | B_GRA | B_RIN};
      vecs[23] = '{mk_ir(22), 1'b0, 3, B_RUN | B_INPORT | B_GRA | B_RIN};
      vecs[24] = '{mk_ir(11), 1'b0, 4, B_RUN | B_GRC | B_ROUT | B_ZLOWIN | ct(8)};
      vecs[25] = '{mk_ir(14), 1'b0, 4, B_RUN | B_COUT | B_ZLOWIN | ct(1)};
      vecs[26] = '{mk_ir(3),  1'b0, 0, F0};
      vecs[27] = '{mk_ir(3),  1'b0, 1, F1};
      vecs[28] = '{mk_ir(3),  1'b0, 2, F2};

      for (int i = 0; i < NV; i++) begin
         run_to(vecs[i].ir, vecs[i].con, vecs[i].step);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Clear pulled low mid-instruction (andi T4): everything drops at once.
      run_to(32'h68900005, 1'b0, 4);
      Clear = 1'b0;
      #1;
      check("clear_mid_t4", 33'd0);

      // andi ends at T5 and returns to T0.
      run_to(32'h68900005, 1'b0, 5);
      tick();
      check("andi_next_t0", F0);

      // st: wren for exactly one cycle, then T0.
      run_to(mk_ir(2), 1'b0, 7);
      check("st_t7_wren", B_RUN | B_WREN);
      tick();
      check("st_after_t7", F0);

      // mul: 7 cycles from T0 to the next T0.
      run_to(mk_ir(15), 1'b0, 0);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (w_dut === F0) begin
            n = k;
            break;
         end
      end
      check_int("mul_cycle_len", n, 7);

      // halt opcode parks in HALT; Stop activity does not resume.
      run_to(mk_ir(27), 1'b0, 2);
      for (int k = 0; k < 20; k++) begin
         @(negedge Clock);
         Stop = 1'($urandom_range(0, 1));
         #1;
         check("halt_hold", 33'd0);
      end

      // Stop raised during add's T5 halts at the boundary.
      run_to(mk_ir(3), 1'b0, 5);
      Stop = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         Stop = 1'b0;
         check("stop_hold", 33'd0);
      end

      // Illegal opcode 31 behaves as nop: T2 straight back to T0.
      run_to(mk_ir(31), 1'b0, 2);
      tick();
      check("illegal_to_t0", F0);

      rand_phase(3000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's control inputs: one state per clock, fetch (T0–T2) then opcode-dependent execute (T3–T7).
- Sits directly upstream of the datapath. It consumes IR and the CON flip-flop result, and produces every strobe that the datapath benches currently drive by hand.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- CTRLW, 4, ALU ctrl width.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous active-low reset (0 = reset).
- IR  in  32  instruction register contents.
- CON_FF  in  1  branch condition from datapath.
- Stop  in  1  request halt at instruction boundary.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus drive strobes.
- MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, Rin, CONin, outPortEnable  out  1 each  register load strobes.
- Gra, Grb, Grc  out  1 each  register-field selects.
- IncPC, Read, wren  out  1 each  PC increment, memory read, memory write.
- ctrl  out  4  ALU operation code.
- Run  out  1  1 while executing, 0 in HALT.

Behaviour:
- States:
  - RST, T0–T7, HALT.
  - Outputs are a combinational function of (state, opcode). Any strobe not listed for a state is 0.
  - ctrl defaults to 0 (AND).
- Reset:
  - Clear=0 forces RST asynchronously; all outputs are 0 immediately, including mid-instruction.
  - In RST, Run=1 once Clear=1.
  - RST goes to T0 on the first rising edge after release.
- ALU ctrl codes: AND 0, OR 1, ADD 2, SUB 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, MUL 9, DIV 10, NEG 11, NOT 12.
- Opcodes:
  - ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11.
  - addi 12, andi 13, ori 14, mul 15, div 16, neg 17, not 18, br 19, jr 20, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27.
  - Any other opcode is treated as nop.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute sequences:
  - Reg ALU (add..rol):
    - T3 Grb Rout Yin.
    - T4 Grc Rout ctrl=op Zlowin.
    - T5 Zlowout Gra Rin.
  - Immediate (addi/andi/ori):
    - T3 Grb Rout Yin.
    - T4 Cout ctrl=ADD/AND/OR Zlowin.
    - T5 Zlowout Gra Rin.
  - mul/div:
    - T3 Gra Rout Yin.
    - T4 Grb Rout ctrl Zlowin Zhighin.
    - T5 Zlowout LOin.
    - T6 Zhighout HIin.
  - neg/not:
    - T3 Grb Rout ctrl Zlowin.
    - T4 Zlowout Gra Rin.
  - ld:
    - T3 Grb BAout Yin.
    - T4 Cout ctrl=ADD Zlowin.
    - T5 Zlowout MARin.
    - T6 Read MDRin.
    - T7 MDRout Gra Rin.
  - ldi: T3–T4 as ld, then T5 Zlowout Gra Rin.
  - st:
    - T3–T5 as ld.
    - T6 Gra Rout MDRin (Read=0).
    - T7 wren.
  - br:
    - T3 Gra Rout CONin.
    - T4 PCout Yin.
    - T5 Cout ctrl=ADD Zlowin.
    - T6 Zlowout and PCin, both asserted only if CON_FF=1.
  - Single-step instructions, all in T3:
    - jr: Gra Rout PCin.
    - in: InPortout Gra Rin.
    - out: Gra Rout outPortEnable.
    - mfhi: HIout Gra Rin.
    - mflo: LOout Gra Rin.
  - nop: after T2 go directly to T0.
  - halt: after T2 go to HALT.
- Last step:
  - After an instruction's last step, the next state is T0.
  - If Stop=1 at that edge, the next state is HALT instead.
- HALT:
  - All strobes 0, Run=0.
  - Stays in HALT until Clear=0; Stop deassertion does not resume.
- Opcode is taken from IR during T3–T7. IR changes only at the T2 edge.

Decomposition:
- Package control_pkg holds:
  - state encoding;
  - opcode constants;
  - ALU ctrl constants;
  - sequence-length lookup (last step per opcode).
- One sub-module, step_decoder: combinational (state, opcode, CON_FF) → strobe vector. The top holds the state register and the next-state logic.

Test Plan:
- Reset, then Clear=1: RST for one cycle, then T0 with PCout=MARin=IncPC=Zlowin=1. Pull Clear low during T4: all outputs 0 in the same timestep.
- IR=0x68900005 (andi): T3 Grb Rout Yin; T4 Cout ctrl=0 Zlowin; T5 Zlowout Gra Rin; next cycle T0.
- ld then st (IR opcode 0, then 2): ld T6 Read MDRin, T7 MDRout Gra Rin. st T6 Gra Rout MDRin with Read=0, T7 wren=1 for exactly one cycle.
- br with CON_FF=0, then with CON_FF=1: T6 PCin=0 in the first case, PCin=Zlowout=1 in the second.
- mul (opcode 15): T4 ctrl=9 Zlowin Zhighin; T5 LOin; T6 HIin; 7 cycles from T0 to the next T0.
- halt opcode, plus Stop=1 raised during an add's T5: both reach HALT with Run=0 and hold 20 cycles with all strobes 0. An illegal opcode (31) returns to T0 after T2.
